// File: rtl/rf_wb_arb.sv
// rf_wb_arb: writeback arbiter feeding the 6R3W register file (optional macro WB_SECOND_ALU_PORT_EN enables ALU1 on port2)
module rf_wb_arb #(
    parameter int WIDTH        = 64,
    parameter int LG_DEPTH     = 7,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                clk_i,
    input  logic                reset_i,
    input  logic                alu0_valid_i,
    input  logic [LG_DEPTH-1:0] alu0_ptr_i,
    input  logic [WIDTH-1:0]    alu0_data_i,
    input  logic                alu1_valid_i,
    input  logic [LG_DEPTH-1:0] alu1_ptr_i,
    input  logic [WIDTH-1:0]    alu1_data_i,
    input  logic                md_valid_i,
    input  logic [LG_DEPTH-1:0] md_ptr_i,
    input  logic [WIDTH-1:0]    md_data_i,
    output logic                md_ready_o,
    input  logic                mem_valid_i,
    input  logic [LG_DEPTH-1:0] mem_ptr_i,
    input  logic [WIDTH-1:0]    mem_data_i,
    output logic                wen0_o,
    output logic                wen1_o,
    output logic                wen2_o,
    output logic [LG_DEPTH-1:0] wrptr0_o,
    output logic [LG_DEPTH-1:0] wrptr1_o,
    output logic [LG_DEPTH-1:0] wrptr2_o,
    output logic [WIDTH-1:0]    wr0_o,
    output logic [WIDTH-1:0]    wr1_o,
    output logic [WIDTH-1:0]    wr2_o,
    output logic [2:0]          wake_vec_o,
    output logic                alu_hold_o,
    output logic                bank_err_o
);
    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_HOLD} state_t;
    localparam int MSB = LG_DEPTH - 1;
    state_t              state_q;
    logic [3:0]          cnt_q;
    logic                alu_hold_q, bank_err_q;
    logic                wen0_q, wen1_q, wen2_q;
    logic [LG_DEPTH-1:0] wrptr0_q, wrptr1_q, wrptr2_q;
    logic [WIDTH-1:0]    wr0_q, wr1_q, wr2_q;
    logic                slot, md_acc, stall;
    logic                s0_v, s2_v;
    logic [LG_DEPTH-1:0] s0_ptr, s2_ptr;
    logic [WIDTH-1:0]    s0_data, s2_data;
    logic                wen0_d, wen1_d, wen2_d, dup, bank_err_d;
`ifdef WB_SECOND_ALU_PORT_EN
    assign slot    = !alu0_valid_i || !alu1_valid_i;
    assign s2_v    = alu1_valid_i || (md_valid_i && alu0_valid_i);
    assign s2_ptr  = alu1_valid_i ? alu1_ptr_i : md_ptr_i;
    assign s2_data = alu1_valid_i ? alu1_data_i : md_data_i;
`else
    logic unused_alu1;
    assign unused_alu1 = ^{alu1_valid_i, alu1_ptr_i, alu1_data_i};
    assign slot    = !alu0_valid_i;
    assign s2_v    = 1'b0;
    assign s2_ptr  = '0;
    assign s2_data = '0;
`endif
    assign md_ready_o = slot && !reset_i;
    assign md_acc     = md_valid_i && md_ready_o;
    assign stall      = md_valid_i && !md_ready_o;
    assign s0_v       = alu0_valid_i || md_valid_i;
    assign s0_ptr     = alu0_valid_i ? alu0_ptr_i : md_ptr_i;
    assign s0_data    = alu0_valid_i ? alu0_data_i : md_data_i;
    // preg 0 is hardwired zero: the handshake completes but no write is issued
    assign wen0_d = s0_v && |s0_ptr;
    assign wen1_d = mem_valid_i && |mem_ptr_i;
    assign wen2_d = s2_v && |s2_ptr;
    assign dup = (wen0_d && wen1_d && s0_ptr == mem_ptr_i) ||
                 (wen0_d && wen2_d && s0_ptr == s2_ptr) ||
                 (wen1_d && wen2_d && mem_ptr_i == s2_ptr);
    assign bank_err_d = bank_err_q || (s0_v && s0_ptr[MSB]) || (s2_v && s2_ptr[MSB]) ||
                        (mem_valid_i && !mem_ptr_i[MSB]) || dup;
    assign wen0_o     = wen0_q;
    assign wen1_o     = wen1_q;
    assign wen2_o     = wen2_q;
    assign wrptr0_o   = wrptr0_q;
    assign wrptr1_o   = wrptr1_q;
    assign wrptr2_o   = wrptr2_q;
    assign wr0_o      = wr0_q;
    assign wr1_o      = wr1_q;
    assign wr2_o      = wr2_q;
    assign wake_vec_o = {wen2_q, wen1_q, wen0_q};
    assign alu_hold_o = alu_hold_q;
    assign bank_err_o = bank_err_q;
    // Register the write ports; pointer and data hold whenever the enable is low
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            {wen0_q, wen1_q, wen2_q} <= '0;
            {wrptr0_q, wrptr1_q, wrptr2_q} <= '0;
            {wr0_q, wr1_q, wr2_q} <= '0;
            bank_err_q <= 1'b0;
        end else begin
            wen0_q     <= wen0_d;
            wen1_q     <= wen1_d;
            wen2_q     <= wen2_d;
            bank_err_q <= bank_err_d;
            if (wen0_d) begin
                wrptr0_q <= s0_ptr;
                wr0_q    <= s0_data;
            end
            if (wen1_d) begin
                wrptr1_q <= mem_ptr_i;
                wr1_q    <= mem_data_i;
            end
            if (wen2_d) begin
                wrptr2_q <= s2_ptr;
                wr2_q    <= s2_data;
            end
        end
    end
    // Starvation tracker: counts stalled mul/div cycles and raises alu_hold at the limit
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            alu_hold_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: if (stall) begin
                    state_q    <= (STARVE_LIMIT == 1) ? S_HOLD : S_WAIT;
                    alu_hold_q <= (STARVE_LIMIT == 1);
                    cnt_q      <= 4'd1;
                end
                S_WAIT: if (!stall) begin
                    state_q <= S_IDLE;
                    cnt_q   <= '0;
                end else begin
                    cnt_q <= cnt_q + 4'd1;
                    if (cnt_q + 4'd1 == 4'(STARVE_LIMIT)) begin
                        state_q    <= S_HOLD;
                        alu_hold_q <= 1'b1;
                    end
                end
                default: if (!stall) begin
                    state_q    <= S_IDLE;
                    cnt_q      <= '0;
                    alu_hold_q <= 1'b0;
                end
            endcase
        end
    end
endmodule
